// File: rtl/line_window_buffer.sv
// Line window buffer: keeps the previous ROWS-1 video lines and emits, per accepted
// pixel, a vertical column of ROWS pixels at the same x, one cycle later.
module line_window_buffer #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned LINE_LEN  = 320,
    parameter int unsigned ROWS      = 3,
    parameter int unsigned MAX_LINES = 240
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_SOF,
    input  logic                          i_DV,
    input  logic [WIDTH-1:0]              i_Data,
    output logic                          o_DV,
    output logic [WIDTH*ROWS-1:0]         o_Col,
    output logic [$clog2(LINE_LEN)-1:0]   o_X,
    output logic [$clog2(MAX_LINES)-1:0]  o_Y,
    output logic                          o_Win_Valid,
    output logic                          o_EOL,
    output logic                          o_EOF
);

    localparam int unsigned XW = $clog2(LINE_LEN);
    localparam int unsigned YW = $clog2(MAX_LINES);
    localparam int unsigned NB = ROWS - 1;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CW = WIDTH * ROWS;

    logic [XW-1:0]    x_q, x_d, x_cur;
    logic [YW-1:0]    y_q, y_d, y_cur;
    logic [BW-1:0]    wb_q, wb_d, wb_cur;
    logic             last_x_c, last_y_c;

    logic [WIDTH-1:0] bank_mem [0:NB-1][0:LINE_LEN-1];

    logic [CW-1:0]    col_q, col_d;
    logic [XW-1:0]    xo_q;
    logic [YW-1:0]    yo_q;
    logic             dv_q, win_q, eol_q, eof_q;

    // Position of the pixel presented this cycle; SOF forces it to the frame origin.
    always_comb begin
        x_cur    = i_SOF ? '0 : x_q;
        y_cur    = i_SOF ? '0 : y_q;
        wb_cur   = i_SOF ? '0 : wb_q;
        last_x_c = (x_cur == XW'(LINE_LEN - 1));
        last_y_c = (y_cur == YW'(MAX_LINES - 1));
    end

    // Counter and bank-pointer advance.
    always_comb begin
        x_d  = x_cur;
        y_d  = y_cur;
        wb_d = wb_cur;
        if (i_DV) begin
            if (last_x_c) begin
                x_d  = '0;
                y_d  = last_y_c ? '0 : y_cur + YW'(1);
                wb_d = (wb_cur == BW'(NB - 1)) ? '0 : wb_cur + BW'(1);
            end else begin
                x_d = x_cur + XW'(1);
            end
        end
    end

    // Column assembly: bank reads are captured at accept time (read-first against the write).
    always_comb begin
        col_d = col_q;
        if (i_DV) begin
            col_d[WIDTH-1:0] = i_Data;
            for (int unsigned k = 1; k < ROWS; k++) begin
                if (k > 32'(y_cur)) begin
                    col_d[k*WIDTH +: WIDTH] = '0;
                end else begin
                    col_d[k*WIDTH +: WIDTH] = bank_mem[BW'((32'(wb_cur) + k) % NB)][x_cur];
                end
            end
        end
    end

    // Line banks: contents survive reset, masking hides anything stale.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst && i_DV) begin
            bank_mem[wb_cur][x_cur] <= i_Data;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            x_q   <= '0;
            y_q   <= '0;
            wb_q  <= '0;
            dv_q  <= 1'b0;
            col_q <= '0;
            xo_q  <= '0;
            yo_q  <= '0;
            win_q <= 1'b0;
            eol_q <= 1'b0;
            eof_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            wb_q  <= wb_d;
            dv_q  <= i_DV;
            col_q <= col_d;
            if (i_DV) begin
                xo_q <= x_cur;
                yo_q <= y_cur;
            end
            win_q <= i_DV && (32'(y_cur) >= NB);
            eol_q <= i_DV && last_x_c;
            eof_q <= i_DV && last_x_c && last_y_c;
        end
    end

    assign o_DV        = dv_q;
    assign o_Col       = col_q;
    assign o_X         = xo_q;
    assign o_Y         = yo_q;
    assign o_Win_Valid = win_q;
    assign o_EOL       = eol_q;
    assign o_EOF       = eof_q;

endmodule
